// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-buffer latency compensation
// and a built-in test-pattern source.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIX_W    = 8,
  parameter int PIPE     = 2,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] pixel_in,
  output logic [X_W-1:0]   pos_x,
  output logic [Y_W-1:0]   pos_y,
  output logic             pix_req,
  output logic [PIX_W-1:0] pixel_out,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start,
  output logic             line_start
);

  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam int XB_W   = X_W + 3;
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  function automatic logic [PIX_W-1:0] bar_level(input int k);
    longint full;
    full = (longint'(1) << PIX_W) - 1;
    return PIX_W'((longint'(7 - k) * full) / 7);
  endfunction

  localparam logic [PIX_W-1:0] BAR_LUT [8] = '{
    bar_level(0), bar_level(1), bar_level(2), bar_level(3),
    bar_level(4), bar_level(5), bar_level(6), bar_level(7)
  };

  typedef struct packed {
    logic             active;
    logic             hs;
    logic             vs;
    logic             fflag;
    logic             lflag;
    logic [PIX_W-1:0] pat;
  } stage_t;

  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic [X_W:0]   cx_w;
  logic [Y_W:0]   cy_w;
  logic [1:0]     mode_q;
  logic [1:0]     mode_eff;
  logic           first_px;
  logic [2:0]     bar_k;
  logic           cx5;
  logic           cy5;
  stage_t         s0;
  stage_t         pipe [PIPE];
  stage_t         last;

  assign cx_w     = {1'b0, cx};
  assign cy_w     = {1'b0, cy};
  assign first_px = (cx == '0) && (cy == '0);
  assign pos_x    = cx;
  assign pos_y    = cy;
  assign pix_req  = (cx_w < (X_W+1)'(H_ACTIVE)) && (cy_w < (Y_W+1)'(V_ACTIVE));

  always_ff @(posedge clk) begin
    if (rst) begin
      cx     <= '0;
      cy     <= '0;
      mode_q <= 2'd0;
    end else if (ce) begin
      if (first_px) mode_q <= mode;
      if (cx == X_W'(H_TOTAL - 1)) begin
        cx <= '0;
        if (cy == Y_W'(V_TOTAL - 1)) cy <= '0;
        else                         cy <= cy + Y_W'(1);
      end else begin
        cx <= cx + X_W'(1);
      end
    end
  end

  // Narrow rasters have no bit 5; the checker then degenerates to a flat field.
  if (X_W > 5) begin : g_cx5
    assign cx5 = cx[5];
  end else begin : g_cx5_none
    assign cx5 = 1'b0;
  end
  if (Y_W > 5) begin : g_cy5
    assign cy5 = cy[5];
  end else begin : g_cy5_none
    assign cy5 = 1'b0;
  end

  always_comb begin
    bar_k = 3'd0;
    for (int j = 1; j < 8; j++) begin
      if ({cx, 3'b000} >= XB_W'(j * H_ACTIVE)) bar_k = 3'(j);
    end
  end

  // The pattern for pixel (0,0) is computed in the same step mode_q loads,
  // so it must already follow the incoming mode.
  assign mode_eff = first_px ? mode : mode_q;

  always_comb begin
    s0        = '0;
    s0.active = pix_req;
    s0.hs     = (cx_w >= (X_W+1)'(HS_BEG)) && (cx_w < (X_W+1)'(HS_END));
    s0.vs     = (cy_w >= (Y_W+1)'(VS_BEG)) && (cy_w < (Y_W+1)'(VS_END));
    s0.fflag  = first_px;
    s0.lflag  = (cx == '0) && (cy_w < (Y_W+1)'(V_ACTIVE));
    case (mode_eff)
      2'd1:    s0.pat = BAR_LUT[bar_k];
      2'd2:    s0.pat = {PIX_W{cx5 ^ cy5}};
      default: s0.pat = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) pipe[i] <= '0;
    end else if (ce) begin
      pipe[0] <= s0;
      for (int i = 1; i < PIPE; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign last = pipe[PIPE-1];

  // Strobes clear on every clk so they stay one clk wide under any ce duty cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      de          <= 1'b0;
      pixel_out   <= '0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      if (ce) begin
        de          <= last.active;
        hsync       <= last.hs ? HS_ON : ~HS_ON;
        vsync       <= last.vs ? VS_ON : ~VS_ON;
        frame_start <= last.fflag;
        line_start  <= last.lflag;
        if (!last.active)        pixel_out <= '0;
        else if (mode_q == 2'd0) pixel_out <= pixel_in;
        else                     pixel_out <= last.pat;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480, a mid-size raster with
// inverted syncs, and a tiny raster fed by a two-stage frame-buffer model.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // default-parameter instance
  logic       d_rst, d_ce;
  logic [1:0] d_mode;
  logic [7:0] d_pix_in, d_pix_out;
  logic [9:0] d_pos_x, d_pos_y;
  logic       d_pix_req, d_hs, d_vs, d_de, d_fs, d_ls;

  // mid-size instance: H 64/4/8/4 (80), V 40/1/2/1 (44), positive syncs
  logic       m_rst, m_ce;
  logic [1:0] m_mode;
  logic [7:0] m_pix_in, m_pix_out;
  logic [6:0] m_pos_x;
  logic [5:0] m_pos_y;
  logic       m_pix_req, m_hs, m_vs, m_de, m_fs, m_ls;
  int         m_steps;

  // small instance: H 8/2/2/2 (14), V 4/1/1/1 (7)
  logic       s_rst, s_ce;
  logic [1:0] s_mode;
  logic [7:0] s_pix_in, s_pix_out;
  logic [3:0] s_pos_x;
  logic [2:0] s_pos_y;
  logic       s_pix_req, s_hs, s_vs, s_de, s_fs, s_ls;
  logic [6:0] s_mem0, s_mem1;

  vga_timing_gen u_d (
    .clk(clk), .rst(d_rst), .ce(d_ce), .mode(d_mode), .pixel_in(d_pix_in),
    .pos_x(d_pos_x), .pos_y(d_pos_y), .pix_req(d_pix_req), .pixel_out(d_pix_out),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .frame_start(d_fs), .line_start(d_ls));

  vga_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .PIX_W(8), .PIPE(2)
  ) u_m (
    .clk(clk), .rst(m_rst), .ce(m_ce), .mode(m_mode), .pixel_in(m_pix_in),
    .pos_x(m_pos_x), .pos_y(m_pos_y), .pix_req(m_pix_req), .pixel_out(m_pix_out),
    .hsync(m_hs), .vsync(m_vs), .de(m_de), .frame_start(m_fs), .line_start(m_ls));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .PIX_W(8), .PIPE(2)
  ) u_s (
    .clk(clk), .rst(s_rst), .ce(s_ce), .mode(s_mode), .pixel_in(s_pix_in),
    .pos_x(s_pos_x), .pos_y(s_pos_y), .pix_req(s_pix_req), .pixel_out(s_pix_out),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .frame_start(s_fs), .line_start(s_ls));

  // two-step frame-buffer read model: marker = {x, 1, y}
  always @(posedge clk) begin
    if (s_ce) begin
      s_mem0 <= {s_pos_x, s_pos_y};
      s_mem1 <= s_mem0;
    end
  end
  assign s_pix_in = {s_mem1[6:3], 1'b1, s_mem1[2:0]};

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv_m(input int target);
    while (m_steps < target) begin
      clk_step();
      m_steps++;
    end
  endtask

  task automatic reset_m();
    m_rst = 1'b1;
    clk_step();
    clk_step();
    m_rst = 1'b0;
    m_steps = 0;
  endtask

  task automatic test_reset();
    d_rst = 1'b1; m_rst = 1'b1; s_rst = 1'b1;
    clk_step();
    clk_step();
    tests_run++;
    if ({d_de, d_pix_out, d_hs, d_vs, d_fs, d_ls} !== {1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_default: de=%b pix=%h hs=%b vs=%b fs=%b ls=%b, want 0 00 1 1 0 0",
               d_de, d_pix_out, d_hs, d_vs, d_fs, d_ls);
    end
    tests_run++;
    if ({m_de, m_pix_out, m_hs, m_vs, m_fs, m_ls} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_pos_pol: de=%b pix=%h hs=%b vs=%b fs=%b ls=%b, want 0 00 0 0 0 0",
               m_de, m_pix_out, m_hs, m_vs, m_fs, m_ls);
    end
    tests_run++;
    if ({d_pos_x, d_pos_y, m_pos_x, m_pos_y, s_pos_x, s_pos_y} !== '0) begin
      tests_failed++;
      $display("FAIL reset_pos: d=%0d,%0d m=%0d,%0d s=%0d,%0d, want all 0",
               d_pos_x, d_pos_y, m_pos_x, m_pos_y, s_pos_x, s_pos_y);
    end
    tests_run++;
    if ({d_pix_req, m_pix_req, s_pix_req} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_pix_req: got %b, want 111", {d_pix_req, m_pix_req, s_pix_req});
    end
    d_rst = 1'b0; m_rst = 1'b0; s_rst = 1'b0;
    m_steps = 0;
  endtask

  task automatic test_default_lines();
    int hs_low = 0, vs_low = 0, de_cnt = 0, req_cnt = 0, fs_cnt = 0, ls_cnt = 0;
    int pix_bad = 0, first_hs = -1, first_de = -1;
    d_mode = 2'd0;
    d_pix_in = 8'h5A;
    d_rst = 1'b1;
    clk_step();
    d_rst = 1'b0;
    for (int k = 1; k <= 1600; k++) begin
      clk_step();
      if (!d_hs) begin hs_low++; if (first_hs < 0) first_hs = k; end
      if (!d_vs) vs_low++;
      if (d_de) begin de_cnt++; if (first_de < 0) first_de = k; end
      if (d_pix_req) req_cnt++;
      if (d_fs) fs_cnt++;
      if (d_ls) ls_cnt++;
      if (d_pix_out !== (d_de ? 8'h5A : 8'h00)) pix_bad++;
    end
    tests_run++;
    if (first_hs !== 659) begin tests_failed++; $display("FAIL def_hsync_start: got %0d want 659", first_hs); end
    tests_run++;
    if (hs_low !== 192) begin tests_failed++; $display("FAIL def_hsync_width: got %0d want 192", hs_low); end
    tests_run++;
    if (vs_low !== 0) begin tests_failed++; $display("FAIL def_vsync_idle: got %0d want 0", vs_low); end
    tests_run++;
    if (first_de !== 3) begin tests_failed++; $display("FAIL def_first_de: got %0d want 3", first_de); end
    tests_run++;
    if (de_cnt !== 1280) begin tests_failed++; $display("FAIL def_de_count: got %0d want 1280", de_cnt); end
    tests_run++;
    if (req_cnt !== 1280) begin tests_failed++; $display("FAIL def_pix_req: got %0d want 1280", req_cnt); end
    tests_run++;
    if (fs_cnt !== 1 || ls_cnt !== 2) begin
      tests_failed++; $display("FAIL def_strobes: fs=%0d ls=%0d want 1 2", fs_cnt, ls_cnt);
    end
    tests_run++;
    if (pix_bad !== 0) begin tests_failed++; $display("FAIL def_pass_pixel: bad=%0d want 0", pix_bad); end
    tests_run++;
    if (d_pos_x !== 10'd0 || d_pos_y !== 10'd2) begin
      tests_failed++; $display("FAIL def_pos_end: got %0d,%0d want 0,2", d_pos_x, d_pos_y);
    end
  endtask

  task automatic test_small_marker();
    int bad = 0, hs_low = 0, vs_low = 0, de_cnt = 0, fs_cnt = 0, ls_cnt = 0;
    int idx, x, y;
    logic [7:0] exp;
    s_mode = 2'd0;
    s_rst = 1'b1;
    clk_step();
    s_rst = 1'b0;
    for (int k = 1; k <= 196; k++) begin
      clk_step();
      idx = k - 3;
      exp = 8'h00;
      if (idx >= 0) begin
        x = idx % 14;
        y = (idx / 14) % 7;
        if (x < 8 && y < 4) exp = 8'((x << 4) | 8 | y);
      end
      if (s_pix_out !== exp) bad++;
      if (!s_hs) hs_low++;
      if (!s_vs) vs_low++;
      if (s_de) de_cnt++;
      if (s_fs) fs_cnt++;
      if (s_ls) ls_cnt++;
      if (k == 3 || k == 10 || k == 11 || k == 22) begin
        tests_run++;
        if (s_pix_out !== exp) begin
          tests_failed++; $display("FAIL small_spot k=%0d: got %h want %h", k, s_pix_out, exp);
        end
      end
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL small_marker: bad=%0d want 0", bad); end
    tests_run++;
    if (hs_low !== 28 || vs_low !== 28) begin
      tests_failed++; $display("FAIL small_syncs: hs=%0d vs=%0d want 28 28", hs_low, vs_low);
    end
    tests_run++;
    if (de_cnt !== 64) begin tests_failed++; $display("FAIL small_de: got %0d want 64", de_cnt); end
    tests_run++;
    if (fs_cnt !== 2 || ls_cnt !== 8) begin
      tests_failed++; $display("FAIL small_strobes: fs=%0d ls=%0d want 2 8", fs_cnt, ls_cnt);
    end
  endtask

  task automatic test_ce_quarter();
    int fs_cnt = 0, ls_cnt = 0, de_cnt = 0, wide = 0, hold_bad = 0;
    logic fs_prev = 1'b0, ls_prev = 1'b0;
    m_mode = 2'd0;
    m_pix_in = 8'hC3;
    m_ce = 1'b1;
    reset_m();
    for (int it = 1; it <= 3523; it++) begin
      m_ce = 1'b1;
      for (int c = 0; c < 4; c++) begin
        clk_step();
        m_ce = 1'b0;
        if (m_fs) fs_cnt++;
        if (m_ls) ls_cnt++;
        if (m_de) de_cnt++;
        if ((m_fs && fs_prev) || (m_ls && ls_prev)) wide++;
        fs_prev = m_fs;
        ls_prev = m_ls;
        if (it == 10 && m_pos_x !== 7'd10) hold_bad++;
      end
    end
    m_ce = 1'b1;
    tests_run++;
    if (fs_cnt !== 2) begin tests_failed++; $display("FAIL ce4_frame_start: got %0d want 2", fs_cnt); end
    tests_run++;
    if (ls_cnt !== 41) begin tests_failed++; $display("FAIL ce4_line_start: got %0d want 41", ls_cnt); end
    tests_run++;
    if (wide !== 0) begin tests_failed++; $display("FAIL ce4_strobe_width: wide=%0d want 0", wide); end
    tests_run++;
    if (de_cnt !== 10244) begin tests_failed++; $display("FAIL ce4_de_clks: got %0d want 10244", de_cnt); end
    tests_run++;
    if (hold_bad !== 0) begin tests_failed++; $display("FAIL ce4_hold: bad=%0d want 0", hold_bad); end
    tests_run++;
    if (m_pos_x !== 7'd3 || m_pos_y !== 6'd0) begin
      tests_failed++; $display("FAIL ce4_pos_end: got %0d,%0d want 3,0", m_pos_x, m_pos_y);
    end
  endtask

  task automatic test_polarity();
    int hs_s [4] = '{70, 71, 78, 79};
    int vs_s [4] = '{3282, 3283, 3442, 3443};
    logic exp_l [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    m_mode = 2'd0;
    reset_m();
    for (int i = 0; i < 4; i++) begin
      adv_m(hs_s[i]);
      tests_run++;
      if (m_hs !== exp_l[i]) begin
        tests_failed++; $display("FAIL pol_hsync step %0d: got %b want %b", hs_s[i], m_hs, exp_l[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      adv_m(vs_s[i]);
      tests_run++;
      if (m_vs !== exp_l[i]) begin
        tests_failed++; $display("FAIL pol_vsync step %0d: got %b want %b", vs_s[i], m_vs, exp_l[i]);
      end
    end
  endtask

  task automatic test_modes();
    logic [7:0] bars [8] = '{8'hFF, 8'hDA, 8'hB6, 8'h91, 8'h6D, 8'h48, 8'h24, 8'h00};
    int ck_x [8] = '{0, 31, 32, 63, 0, 0, 32, 63};
    int ck_y [8] = '{0, 0, 0, 0, 31, 32, 32, 39};
    logic [7:0] ck_v [8] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    int bad = 0, de_cnt = 0, nz = 0, s;
    m_mode = 2'd0;
    m_pix_in = 8'h3C;
    reset_m();
    adv_m(999);
    m_mode = 2'd1;
    for (int t = 1000; t <= 3522; t++) begin
      adv_m(t);
      if (m_de) begin de_cnt++; if (m_pix_out !== 8'h3C) bad++; end
    end
    tests_run++;
    if (bad !== 0 || de_cnt !== 1755) begin
      tests_failed++; $display("FAIL mode_no_tear: bad=%0d de=%0d want 0 1755", bad, de_cnt);
    end
    for (int b = 0; b < 8; b++) begin
      for (int off = 0; off < 8; off += 7) begin
        adv_m(3523 + 8 * b + off);
        tests_run++;
        if (m_pix_out !== bars[b]) begin
          tests_failed++; $display("FAIL mode_bars x=%0d: got %h want %h", 8 * b + off, m_pix_out, bars[b]);
        end
      end
    end
    m_mode = 2'd2;
    for (int i = 0; i < 8; i++) begin
      s = 7043 + 80 * ck_y[i] + ck_x[i];
      adv_m(s);
      tests_run++;
      if (m_pix_out !== ck_v[i]) begin
        tests_failed++;
        $display("FAIL mode_checker (%0d,%0d): got %h want %h", ck_x[i], ck_y[i], m_pix_out, ck_v[i]);
      end
    end
    m_mode = 2'd3;
    de_cnt = 0;
    for (int t = 10563; t <= 10642; t++) begin
      adv_m(t);
      if (m_de) de_cnt++;
      if (m_pix_out !== 8'h00) nz++;
    end
    tests_run++;
    if (de_cnt !== 64 || nz !== 0) begin
      tests_failed++; $display("FAIL mode_black: de=%0d nonzero=%0d want 64 0", de_cnt, nz);
    end
    m_mode = 2'd0;
  endtask

  task automatic test_reset_midline();
    m_mode = 2'd0;
    m_pix_in = 8'h3C;
    reset_m();
    adv_m(1650);
    tests_run++;
    if (m_pos_x !== 7'd50 || m_pos_y !== 6'd20 || m_de !== 1'b1) begin
      tests_failed++; $display("FAIL rst_mid_pre: pos=%0d,%0d de=%b want 50,20 1", m_pos_x, m_pos_y, m_de);
    end
    m_rst = 1'b1;
    clk_step();
    tests_run++;
    if ({m_pos_x, m_pos_y, m_de, m_hs, m_vs, m_pix_out} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_state: pos=%0d,%0d de=%b hs=%b vs=%b pix=%h want all 0",
               m_pos_x, m_pos_y, m_de, m_hs, m_vs, m_pix_out);
    end
    m_rst = 1'b0;
    m_steps = 0;
    for (int k = 1; k <= 4; k++) begin
      clk_step();
      tests_run++;
      if (m_fs !== (k == 3) || m_de !== (k >= 3)) begin
        tests_failed++;
        $display("FAIL rst_mid_release k=%0d: fs=%b de=%b want %b %b", k, m_fs, m_de, (k == 3), (k >= 3));
      end
    end
  endtask

  initial begin
    d_ce = 1'b1; m_ce = 1'b1; s_ce = 1'b1;
    d_mode = 2'd0; m_mode = 2'd0; s_mode = 2'd0;
    d_pix_in = 8'h00; m_pix_in = 8'h00;
    d_rst = 1'b1; m_rst = 1'b1; s_rst = 1'b1;
    m_steps = 0;
    test_reset();
    test_default_lines();
    test_small_marker();
    test_ce_quarter();
    test_polarity();
    test_modes();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
